// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 codec-control I2C write master.
package wm8731_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } i2c_state_e;

  localparam logic [7:0] WM8731_ADDR_W = 8'h34;

  // Byte fields of the 24-bit control word, sent MSB first
  localparam int PKT_W        = 24;
  localparam int PKT_ADDR_MSB = 23;
  localparam int PKT_ADDR_LSB = 16;
  localparam int PKT_REG_MSB  = 15;
  localparam int PKT_REG_LSB  = 8;
  localparam int PKT_DAT_MSB  = 7;
  localparam int PKT_DAT_LSB  = 0;

  localparam int QTR_DIV_DEF  = 125;

endpackage

// File: rtl/wm8731_i2c_write_master_if.sv
// Packet handshake plus I2C pad signals between the control sequencer, the master and the pads.
interface wm8731_i2c_write_master_if;
  import wm8731_pkg::*;

  logic [PKT_W-1:0] i2c_packet;
  logic             wr_i2c;
  logic             busy;
  logic             done;
  logic             ack_err;
  logic             i2c_sclk;
  logic             i2c_sdat_oe;
  logic             i2c_sdat_in;

  modport master (
    input  i2c_packet, wr_i2c, i2c_sdat_in,
    output busy, done, ack_err, i2c_sclk, i2c_sdat_oe
  );

  modport slave (
    output i2c_packet, wr_i2c, i2c_sdat_in,
    input  busy, done, ack_err, i2c_sclk, i2c_sdat_oe
  );

endinterface

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-period divider: one-cycle qtick every QTR_DIV clocks while run is high.
module i2c_qtick_gen #(
  parameter int QTR_DIV = 125,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic qtick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(QTR_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run)       cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  assign qtick = run && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wm8731_i2c_write_master.sv
// Serialises one 24-bit WM8731 control word per strobe as a 3-byte I2C write with ACK checking.
module wm8731_i2c_write_master
  import wm8731_pkg::*;
#(
  parameter int QTR_DIV = QTR_DIV_DEF,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset_n,
  wm8731_i2c_write_master_if.master bus
);

  i2c_state_e       state_q, state_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic             scl_q, scl_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic [1:0]       sync_q, sync_d;
  logic             accept, qtick, sda_sync;

  assign accept   = (state_q == ST_IDLE) && bus.wr_i2c;
  assign sda_sync = sync_q[1];
  assign sync_d   = {sync_q[0], bus.i2c_sdat_in};

  i2c_qtick_gen #(.QTR_DIV(QTR_DIV), .CNT_W(CNT_W)) u_qtick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state_q != ST_IDLE),
    .clr     (accept),
    .qtick   (qtick)
  );

  // Each qtick closes the current quarter and sets the pads for the next one.
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    scl_d     = scl_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d   = ST_START;
        qtr_d     = 2'd0;
        bit_d     = 3'd7;
        byte_d    = 2'd0;
        shreg_d   = bus.i2c_packet;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        scl_d     = 1'b1;
        oe_d      = 1'b0;
      end
      ST_START: if (qtick) begin
        if (qtr_q == 2'd0) begin
          qtr_d = 2'd1;
          oe_d  = 1'b1;
        end else begin
          state_d = ST_BIT;
          qtr_d   = 2'd0;
          scl_d   = 1'b0;
          oe_d    = ~shreg_q[PKT_W-1];
        end
      end
      ST_BIT: if (qtick) begin
        case (qtr_q)
          2'd0: begin qtr_d = 2'd1; scl_d = 1'b1; end
          2'd1: qtr_d = 2'd2;
          2'd2: begin qtr_d = 2'd3; scl_d = 1'b0; end
          2'd3: begin
            qtr_d   = 2'd0;
            shreg_d = shreg_q << 1;
            if (bit_q == 3'd0) begin
              state_d = ST_ACK;
              oe_d    = 1'b0;
            end else begin
              bit_d = bit_q - 3'd1;
              oe_d  = ~shreg_q[PKT_W-2];
            end
          end
        endcase
      end
      ST_ACK: if (qtick) begin
        case (qtr_q)
          2'd0: begin qtr_d = 2'd1; scl_d = 1'b1; end
          2'd1: begin
            qtr_d = 2'd2;
            if (sda_sync) ack_err_d = 1'b1;
          end
          2'd2: begin qtr_d = 2'd3; scl_d = 1'b0; end
          2'd3: begin
            qtr_d = 2'd0;
            // ack_err is cleared on acceptance, so here it means this transfer saw a NACK
            if (ack_err_q || byte_q == 2'd2) begin
              state_d = ST_STOP;
              oe_d    = 1'b1;
            end else begin
              state_d = ST_BIT;
              byte_d  = byte_q + 2'd1;
              bit_d   = 3'd7;
              oe_d    = ~shreg_q[PKT_W-1];
            end
          end
        endcase
      end
      ST_STOP: if (qtick) begin
        case (qtr_q)
          2'd0:    begin qtr_d = 2'd1; scl_d = 1'b1; end
          2'd1:    begin qtr_d = 2'd2; oe_d = 1'b0; end
          default: begin
            state_d = ST_DONE;
            qtr_d   = 2'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      byte_q    <= 2'd0;
      shreg_q   <= '0;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      scl_q     <= scl_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.i2c_sclk    = scl_q;
  assign bus.i2c_sdat_oe = oe_q;

endmodule

// File: tb/tb_wm8731_i2c_write_master.sv
// Scoreboard bench: reference model queues expected bus tokens and done records; monitors pop and compare.
module tb_wm8731_i2c_write_master;
  import wm8731_pkg::*;

  localparam int Q         = 4;
  localparam int TOK_START = 256;
  localparam int TOK_STOP  = 512;

  typedef struct {
    int scyc;
    int lat;
    bit aerr;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wm8731_i2c_write_master_if bus();

  wm8731_i2c_write_master #(.QTR_DIV(Q), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int        n_chk = 0;
  int        n_pass = 0;
  int        cyc = 0;
  int        nack_cfg = -1;
  bit        prev_aerr = 1'b0;
  int        exp_tok[$];
  done_exp_t exp_done[$];

  logic pull = 1'b0;
  assign bus.i2c_sdat_in = ~(bus.i2c_sdat_oe | pull);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Reference model: which bytes reach the bus and how many quarters the transfer takes
  function automatic void model_push(input logic [23:0] pkt, input int nack, input int scyc);
    logic [7:0] by [3];
    int nb;
    by[0] = pkt[PKT_ADDR_MSB:PKT_ADDR_LSB];
    by[1] = pkt[PKT_REG_MSB:PKT_REG_LSB];
    by[2] = pkt[PKT_DAT_MSB:PKT_DAT_LSB];
    nb = (nack < 0) ? 3 : nack + 1;
    exp_tok.push_back(TOK_START);
    for (int b = 0; b < nb; b++) exp_tok.push_back(int'(by[b]));
    exp_tok.push_back(TOK_STOP);
    exp_done.push_back('{scyc, (2 + nb * 36 + 3) * Q + 1, nack >= 0});
    prev_aerr = (nack >= 0);
  endfunction

  task automatic tok(input int v);
    if (exp_tok.size() == 0) begin
      n_chk++;
      $display("FAIL bus_unexpected actual=%0h required=none", v);
    end else chk("bus_token", v, exp_tok.pop_front());
  endtask

  // I2C slave + protocol decoder on the wired-AND SDA line
  logic p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0;
  int   bit_n = 0, byte_n = 0, last_stop = -1;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    logic scl, sda;
    scl = bus.i2c_sclk;
    sda = bus.i2c_sdat_in;
    if (!reset_n) begin
      bit_n <= 0; pull <= 1'b0; in_frame <= 1'b0; last_stop <= -1;
    end else if (p_scl && scl) begin
      if (p_sda && !sda) begin
        tok(TOK_START);
        if (last_stop >= 0) chk("bus_idle_gap", int'((cyc - last_stop) >= Q), 1);
        bit_n <= 0; byte_n <= 0; in_frame <= 1'b1;
      end else if (!p_sda && sda) begin
        tok(TOK_STOP);
        in_frame <= 1'b0; last_stop <= cyc;
      end
    end else if (!p_scl && scl && in_frame) begin
      if (bit_n < 8) sh <= {sh[6:0], sda};
      if (bit_n == 7) tok(int'({sh[6:0], sda}));
      bit_n <= bit_n + 1;
    end else if (p_scl && !scl && in_frame) begin
      if (bit_n == 8) pull <= (byte_n != nack_cfg);
      else if (bit_n == 9) begin pull <= 1'b0; bit_n <= 0; byte_n <= byte_n + 1; end
    end
    p_scl <= scl;
    p_sda <= sda;
  end

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (exp_done.size() == 0) begin
        n_chk++;
        $display("FAIL done_unexpected actual=1 required=0 at cycle %0d", cyc);
      end else begin
        done_exp_t e;
        e = exp_done.pop_front();
        chk("done_latency", cyc - e.scyc, e.lat);
        chk("ack_err_at_done", int'(bus.ack_err), int'(e.aerr));
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  // Called at a negedge while the DUT is idle; strobes for exactly one cycle
  task automatic send(input logic [23:0] pkt, input int nack);
    chk("ack_err_hold", int'(bus.ack_err), int'(prev_aerr));
    nack_cfg = nack;
    bus.i2c_packet = pkt;
    bus.wr_i2c = 1'b1;
    model_push(pkt, nack, cyc);
    @(negedge clk);
    bus.wr_i2c = 1'b0;
    bus.i2c_packet = 24'($urandom);
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("ack_err_cleared", int'(bus.ack_err), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 2000);
    if (!bus.done) begin
      n_chk++;
      $display("FAIL done_timeout actual=0 required=1 after %0d cycles", n);
    end
  endtask

  task automatic decoy_pulse();
    bus.wr_i2c = 1'b1;
    bus.i2c_packet = 24'hFFFFFF;
    @(negedge clk);
    bus.wr_i2c = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pkt;
    int nk;
    bus.wr_i2c = 1'b0;
    bus.i2c_packet = '0;

    // 1: reset, release mid-cycle, then idle bus
    repeat (5) @(negedge clk);
    chk("reset_outputs", int'({bus.i2c_sclk, bus.i2c_sdat_oe, bus.busy, bus.done, bus.ack_err}), 'b10000);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({bus.i2c_sclk, bus.i2c_sdat_oe, bus.busy, bus.done, bus.ack_err}), 'b10000);
    end

    // 2: WM8731 reset register write
    send({WM8731_ADDR_W, 8'h1E, 8'h00}, -1);
    wait_done();
    @(negedge clk);

    // 3: NACK on byte 1
    send(24'hAA3CC3, 1);
    wait_done();
    repeat (20) @(negedge clk);
    chk("ack_err_sticky", int'(bus.ack_err), 1);

    // 4: strobes during busy are ignored
    send(24'h341234, -1);
    repeat (9) @(negedge clk);
    decoy_pulse();
    repeat (189) @(negedge clk);
    decoy_pulse();
    wait_done();
    repeat (30) @(negedge clk);

    // 5: reset during bit 5 of byte 1, then a fresh transfer
    send(24'h34A55A, -1);
    repeat (189) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_scl", int'(bus.i2c_sclk), 1);
    chk("abort_oe", int'(bus.i2c_sdat_oe), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    exp_tok.delete();
    exp_done.delete();
    prev_aerr = 1'b0;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    send(24'h340E4A, -1);
    wait_done();
    @(negedge clk);

    // 6: back-to-back; strobe in the DONE cycle is ignored, first IDLE cycle accepted
    send(24'h3412F0, 0);
    wait_done();
    bus.wr_i2c = 1'b1;
    bus.i2c_packet = 24'hFFFFFF;
    @(negedge clk);
    send(24'h340C07, -1);
    wait_done();

    // random traffic
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      pkt = 24'($urandom);
      nk = int'($urandom_range(0, 5)) - 3;
      if (nk < -1) nk = -1;
      send(pkt, nk);
      wait_done();
    end

    repeat (40) @(negedge clk);
    chk("tok_queue_empty", exp_tok.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
